// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART byte transmitter from NUM_REQ byte sources.
// One byte in flight at a time; optional packet lock holds the grant until req_last.
module uart_tx_sched #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_PKT     = 1,
    parameter int unsigned BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [7:0]                 tx_d,
    output logic                       tx_ena,
    input  logic                       tx_rts,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    input  logic                       err_clr,
    output logic                       err_timeout
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t               state, state_n;
    logic                 lock, lock_n;
    logic [IW-1:0]        rr_ptr, rr_ptr_n;
    logic [IW-1:0]        grant_id_n;
    logic [7:0]           tx_d_n;
    logic                 tx_ena_n;
    logic                 busy_n;
    logic                 err_n;
    logic [CW-1:0]        cnt, cnt_n;

    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [IW-1:0]        winner;
    int unsigned          idx;
    logic [7:0]           lane;

    // Winner search starts just after the last granted requester.
    always_comb begin
        eligible = req_valid;
        if (lock) begin
            eligible = req_valid & (NUM_REQ'(1) << grant_id);
        end
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[IW'(idx)]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

    always_comb begin
        lane = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == IW'(i)) begin
                lane = req_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lock        <= 1'b0;
            rr_ptr      <= IW'(NUM_REQ - 1);
            grant_id    <= '0;
            tx_d        <= 8'h00;
            tx_ena      <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            lock        <= lock_n;
            rr_ptr      <= rr_ptr_n;
            grant_id    <= grant_id_n;
            tx_d        <= tx_d_n;
            tx_ena      <= tx_ena_n;
            busy        <= busy_n;
            err_timeout <= err_n;
            cnt         <= cnt_n;
        end
    end

    // Accept strobe is combinational so the byte is taken in the selecting cycle.
    always_comb begin
        state_n    = state;
        lock_n     = lock;
        rr_ptr_n   = rr_ptr;
        grant_id_n = grant_id;
        tx_d_n     = tx_d;
        cnt_n      = cnt;
        err_n      = err_timeout & ~err_clr;
        req_ready  = '0;

        case (state)
            IDLE: begin
                if (tx_rts && found) begin
                    req_ready  = NUM_REQ'(1) << winner;
                    tx_d_n     = lane;
                    grant_id_n = winner;
                    if ((LOCK_PKT != 0) && !req_last[winner]) begin
                        lock_n = 1'b1;
                    end else begin
                        lock_n   = 1'b0;
                        rr_ptr_n = winner;
                    end
                    state_n = LOAD;
                end
            end
            LOAD: begin
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_rts) begin
                    state_n = WAIT_DONE;
                end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never started: drop the byte and release any lock.
                    err_n   = 1'b1;
                    lock_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_rts) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        tx_ena_n = (state_n == LOAD);
        busy_n   = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a small transmitter model driving tx_rts.
`timescale 1ns/1ps
module tb_uart_tx_sched;

    localparam int unsigned N     = 4;
    localparam int unsigned FRAME = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_d;
    logic           tx_ena;
    logic           tx_rts;
    logic [1:0]     grant_id;
    logic           busy;
    logic           err_clr = 1'b0;
    logic           err_timeout;

    logic           model_on = 1'b1;
    logic           rts_man = 1'b1;
    logic           rts_model = 1'b1;
    int             frame_cnt = 0;

    int             checks = 0;
    int             errors = 0;
    int             bad_rts = 0;
    int             dbl_ena = 0;
    logic           ena_prev = 1'b0;
    int             acc_q[$];
    logic [7:0]     byte_q[$];

    assign tx_rts = model_on ? rts_model : rts_man;

    always #5 clk = ~clk;

    uart_tx_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_d        (tx_d),
        .tx_ena      (tx_ena),
        .tx_rts      (tx_rts),
        .grant_id    (grant_id),
        .busy        (busy),
        .err_clr     (err_clr),
        .err_timeout (err_timeout)
    );

    // Transmitter: busy from the cycle after tx_ena for FRAME+1 cycles.
    always @(posedge clk) begin
        if (tx_ena) begin
            rts_model <= 1'b0;
            frame_cnt <= FRAME;
        end else if (!rts_model) begin
            if (frame_cnt == 0) rts_model <= 1'b1;
            else frame_cnt <= frame_cnt - 1;
        end
    end

    // Record accepts and transmitted bytes; flag protocol violations.
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) acc_q.push_back(i);
            end
            if (tx_ena) byte_q.push_back(tx_d);
            if (tx_ena && !tx_rts) bad_rts++;
            if ((|(req_valid & req_ready)) && !tx_rts) bad_rts++;
            if (tx_ena && ena_prev) dbl_ena++;
            ena_prev <= tx_ena;
        end else begin
            ena_prev <= 1'b0;
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Call right after driving inputs at a falling edge.
    task automatic wait_ready(input int idx);
        bit got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (req_ready[idx]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_ready[%0d]: req_ready=%b after 200 cycles, required bit set", idx, req_ready);
        end
    endtask

    task automatic wait_idle();
        bit got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (!busy && tx_rts && !tx_ena) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wait_idle: busy=%b tx_rts=%b after 200 cycles, required idle", busy, tx_rts);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b exp 0000", req_ready); end
        checks++; if (tx_ena !== 1'b0) begin errors++; $display("FAIL rst_tx_ena: got %b exp 0", tx_ena); end
        checks++; if (tx_d !== 8'h00) begin errors++; $display("FAIL rst_tx_d: got %h exp 00", tx_d); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0d exp 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", err_timeout); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte();
        model_on = 1'b1;
        @(negedge clk);
        req_data[8*2 +: 8] = 8'hA5;
        req_last = 4'b0100;
        req_valid = 4'b0100;
        wait_ready(2);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (tx_ena !== 1'b1) begin errors++; $display("FAIL single_tx_ena: got %b exp 1", tx_ena); end
        checks++; if (tx_d !== 8'hA5) begin errors++; $display("FAIL single_tx_d: got %h exp a5", tx_d); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d exp 2", grant_id); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_pulse: got %b exp 0000", req_ready); end
        @(negedge clk);
        checks++; if (tx_ena !== 1'b0) begin errors++; $display("FAIL single_ena_width: got %b exp 0", tx_ena); end
        wait_idle();
    endtask

    task automatic test_round_robin();
        int base;
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [7:0] exp_b[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        apply_reset();
        model_on = 1'b1;
        base = acc_q.size();
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
        req_last = 4'b1111;
        req_valid = 4'b1111;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (acc_q.size() >= base + 5) break;
        end
        req_valid = '0;
        wait_idle();
        checks++; if (acc_q.size() - base !== 5) begin errors++; $display("FAIL rr_count: got %0d exp 5", acc_q.size() - base); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (acc_q.size() <= base + i || acc_q[base + i] !== exp_id[i]) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %0d exp %0d", i, (acc_q.size() > base + i) ? acc_q[base + i] : -1, exp_id[i]);
            end
            checks++;
            if (byte_q.size() <= base + i || byte_q[base + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL rr_byte[%0d]: got %h exp %h", i, (byte_q.size() > base + i) ? byte_q[base + i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_packet_lock();
        int base;
        int exp_id[4] = '{0, 0, 0, 1};
        logic [7:0] exp_b[4] = '{8'h01, 8'h02, 8'h03, 8'h21};
        apply_reset();
        model_on = 1'b1;
        base = acc_q.size();
        req_data[8*1 +: 8] = 8'h21;
        req_data[8*0 +: 8] = 8'h01;
        req_last = 4'b0010;
        req_valid = 4'b0011;
        wait_ready(0);
        @(posedge clk);
        @(negedge clk);
        req_data[8*0 +: 8] = 8'h02;
        wait_ready(0);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        repeat (30) @(negedge clk);
        checks++; if (acc_q.size() - base !== 2) begin errors++; $display("FAIL lock_stall: got %0d accepts exp 2", acc_q.size() - base); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lock_stall_busy: got %b exp 0", busy); end
        req_data[8*0 +: 8] = 8'h03;
        req_last[0] = 1'b1;
        req_valid[0] = 1'b1;
        wait_ready(0);
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_last[0] = 1'b0;
        wait_ready(1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (acc_q.size() <= base + i || acc_q[base + i] !== exp_id[i]) begin
                errors++;
                $display("FAIL lock_order[%0d]: got %0d exp %0d", i, (acc_q.size() > base + i) ? acc_q[base + i] : -1, exp_id[i]);
            end
            checks++;
            if (byte_q.size() <= base + i || byte_q[base + i] !== exp_b[i]) begin
                errors++;
                $display("FAIL lock_byte[%0d]: got %h exp %h", i, (byte_q.size() > base + i) ? byte_q[base + i] : 8'hxx, exp_b[i]);
            end
        end
    endtask

    task automatic test_timeout();
        model_on = 1'b0;
        rts_man = 1'b1;
        @(negedge clk);
        req_data[8*1 +: 8] = 8'h5A;
        req_last = 4'b0010;
        req_valid = 4'b0010;
        wait_ready(1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        checks++; if (tx_ena !== 1'b1 || tx_d !== 8'h5A) begin errors++; $display("FAIL to_launch: tx_ena=%b tx_d=%h exp 1 5a", tx_ena, tx_d); end
        repeat (12) @(negedge clk);
        checks++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL to_early: err=%b busy=%b exp 0 1", err_timeout, busy); end
        repeat (8) @(negedge clk);
        checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_err: got %b exp 1", err_timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: busy got %b exp 0", busy); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clr: got %b exp 0", err_timeout); end
        model_on = 1'b1;
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        @(negedge clk);
        model_on = 1'b0;
        rts_man = 1'b0;
        req_data[8*3 +: 8] = 8'h3C;
        req_last = 4'b1000;
        req_valid = 4'b1000;
        for (int n = 0; n < 8; n++) begin
            #1;
            if (req_ready !== 4'b0000 || tx_ena !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold: %0d cycles active exp 0", bad); end
        rts_man = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_accept: got %b exp 1000", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        checks++; if (tx_ena !== 1'b1 || tx_d !== 8'h3C || grant_id !== 2'd3) begin
            errors++; $display("FAIL bp_launch: tx_ena=%b tx_d=%h grant=%0d exp 1 3c 3", tx_ena, tx_d, grant_id);
        end
        @(negedge clk);
        rts_man = 1'b0;
        repeat (3) @(negedge clk);
        rts_man = 1'b1;
        wait_idle();
        model_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        model_on = 1'b1;
        req_data[8*1 +: 8] = 8'h77;
        req_last = 4'b0010;
        req_valid = 4'b0010;
        wait_ready(1);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1 || tx_rts !== 1'b0) begin errors++; $display("FAIL mid_in_flight: busy=%b tx_rts=%b exp 1 0", busy, tx_rts); end
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h40 + i);
        req_last = 4'b1111;
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_ena !== 1'b0 || tx_d !== 8'h00 || grant_id !== 2'd0) begin
            errors++; $display("FAIL mid_rst_data: tx_ena=%b tx_d=%h grant=%0d exp 0 00 0", tx_ena, tx_d, grant_id);
        end
        checks++; if (busy !== 1'b0 || err_timeout !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_rst_ctrl: busy=%b err=%b ready=%b exp 0 0 0000", busy, err_timeout, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            #1;
            if (|req_ready) break;
            @(negedge clk);
        end
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart_prio: got %b exp 0001", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_timeout();
        test_back_pressure();
        test_reset_mid();
        checks++; if (bad_rts !== 0) begin errors++; $display("FAIL rts_protocol: %0d violations exp 0", bad_rts); end
        checks++; if (dbl_ena !== 0) begin errors++; $display("FAIL ena_gap: %0d back-to-back pulses exp 0", dbl_ena); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
